// File: rtl/pet_vram_arbiter.sv
// PET video RAM arbiter: time-slices one VRAM between CRTC fetches and the CPU,
// with a one-entry posted write buffer (40/80-col) or direct CPU priority (2001 mode).
module pet_vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cnt31_i,
  input  logic        ce_1m,
  input  logic        pref_have_80_cols,
  input  logic        pref_eoi_blanks,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_we,
  input  logic [9:0]  video_addr,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_cpu_video,
  output logic        load_sr,
  output logic        ce_pixel,
  output logic        ce_8m,
  output logic        wbuf_pending,
  output logic        snow_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {IDLE, VIDEO, WRITE} state_e;

  state_e      state_q, state_d;
  logic        video_q, video_d;
  logic        load_sr_q, load_sr_d;
  logic        ce_pixel_q, ce_pixel_d;
  logic        ce_8m_q, ce_8m_d;
  logic        pending_q, pending_d;
  logic        snow_q, snow_d;
  logic        overrun_q, overrun_d;
  logic [10:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;

  logic        vram_sel;
  logic        capture;
  logic        retire;
  logic        slot_lo, slot_hi, slot_end;
  logic [10:0] cpu_vaddr;
  logic [10:0] vid_vaddr;

  always_comb begin
    vram_sel  = (cpu_addr[15:11] == 5'b10000) ||
                (pref_eoi_blanks && (cpu_addr[15:12] == 4'b1000));
    cpu_vaddr = pref_have_80_cols ? cpu_addr[10:0] : {1'b0, cpu_addr[9:0]};
    vid_vaddr = pref_have_80_cols ? {video_addr, cnt31_i[4]} : {1'b0, video_addr};

    slot_lo  = (cnt31_i == 5'd3) || (pref_have_80_cols && (cnt31_i == 5'd19));
    slot_hi  = (cnt31_i == 5'd5) || (pref_have_80_cols && (cnt31_i == 5'd21));
    slot_end = (cnt31_i == 5'd6) || (pref_have_80_cols && (cnt31_i == 5'd22));

    video_d = video_q;
    if (slot_lo) video_d = 1'b0;
    if (slot_hi) video_d = 1'b1;

    load_sr_d = load_sr_q;
    if (slot_hi)       load_sr_d = 1'b1;
    else if (slot_end) load_sr_d = 1'b0;

    ce_pixel_d = pref_have_80_cols ? cnt31_i[0] : (cnt31_i[1:0] == 2'd1);
    ce_8m_d    = (cnt31_i[1:0] == 2'd1);

    retire  = (state_q == WRITE);
    capture = ~pref_eoi_blanks & ce_1m & cpu_we & vram_sel;

    // A capture during the retire cycle refills the buffer after the old entry drains.
    pending_d  = capture | (pending_q & ~retire);
    overrun_d  = capture & pending_q & ~retire;
    buf_addr_d = capture ? cpu_vaddr : buf_addr_q;
    buf_data_d = capture ? cpu_data  : buf_data_q;

    snow_d = pref_eoi_blanks & vram_sel & ~video_q;

    if (pending_d && video_d) state_d = WRITE;
    else if (!video_d)        state_d = VIDEO;
    else                      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      video_q    <= 1'b1;
      load_sr_q  <= 1'b0;
      ce_pixel_q <= 1'b0;
      ce_8m_q    <= 1'b0;
      pending_q  <= 1'b0;
      snow_q     <= 1'b0;
      overrun_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      video_q    <= video_d;
      load_sr_q  <= load_sr_d;
      ce_pixel_q <= ce_pixel_d;
      ce_8m_q    <= ce_8m_d;
      pending_q  <= pending_d;
      snow_q     <= snow_d;
      overrun_q  <= overrun_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  always_comb begin
    // Reset masks the write strobe so a pending entry is dropped without a pulse.
    vram_we    = ~reset & (retire | (pref_eoi_blanks & cpu_we & vram_sel & ce_1m));
    vram_wdata = retire ? buf_data_q : cpu_data;
    if (retire)
      vram_addr = buf_addr_q;
    else if (vram_sel && (video_q || pref_eoi_blanks))
      vram_addr = cpu_vaddr;
    else
      vram_addr = vid_vaddr;
  end

  assign vram_cpu_video = video_q;
  assign load_sr        = load_sr_q;
  assign ce_pixel       = ce_pixel_q;
  assign ce_8m          = ce_8m_q;
  assign wbuf_pending   = pending_q;
  assign snow_o         = snow_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pet_vram_arbiter.sv
// Self-checking bench for pet_vram_arbiter: phase-schedule model plus a write scoreboard.
module tb_pet_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cnt31_i;
  logic        ce_1m;
  logic        pref_have_80_cols;
  logic        pref_eoi_blanks;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic [9:0]  video_addr;
  logic [10:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_cpu_video;
  logic        load_sr;
  logic        ce_pixel;
  logic        ce_8m;
  logic        wbuf_pending;
  logic        snow_o;
  logic        overrun_o;

  pet_vram_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .cnt31_i           (cnt31_i),
    .ce_1m             (ce_1m),
    .pref_have_80_cols (pref_have_80_cols),
    .pref_eoi_blanks   (pref_eoi_blanks),
    .cpu_addr          (cpu_addr),
    .cpu_data          (cpu_data),
    .cpu_we            (cpu_we),
    .video_addr        (video_addr),
    .vram_addr         (vram_addr),
    .vram_wdata        (vram_wdata),
    .vram_we           (vram_we),
    .vram_cpu_video    (vram_cpu_video),
    .load_sr           (load_sr),
    .ce_pixel          (ce_pixel),
    .ce_8m             (ce_8m),
    .wbuf_pending      (wbuf_pending),
    .snow_o            (snow_o),
    .overrun_o         (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  phase;
  logic m80;
  logic nxt_eoi = 1'b0;
  logic nxt_80  = 1'b0;
  logic nxt_rst = 1'b0;
  logic skip_sched = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (phase %0d)", tag, got, exp, phase);
    end
  endtask

  task automatic push(input logic [10:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Advance one phase, drive the CPU for that phase, then sample at the falling edge.
  task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic force_ce);
    wr_t e;
    logic exp_vid, exp_load, exp_pix, exp_8m;
    @(posedge clk);
    m80 = pref_have_80_cols;
    #1;
    pref_eoi_blanks   = nxt_eoi;
    pref_have_80_cols = nxt_80;
    reset             = nxt_rst;
    phase    = (phase + 1) % 32;
    cnt31_i  = 5'(phase);
    ce_1m    = (phase == 0) || force_ce;
    cpu_we   = we;
    cpu_addr = a;
    cpu_data = d;
    @(negedge clk);
    if (vram_we === 1'b1) begin
      check("we_while_video", vram_cpu_video, 1);
      check("we_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("we_addr", vram_addr, e.a);
        check("we_data", vram_wdata, e.d);
      end
    end
    if (skip_sched) begin
      skip_sched = 1'b0;
    end else begin
      exp_vid  = !((phase == 4 || phase == 5) || (m80 && (phase == 20 || phase == 21)));
      exp_load = (phase == 6) || (m80 && phase == 22);
      exp_pix  = m80 ? (phase % 2 == 0) : (phase % 4 == 2);
      exp_8m   = (phase % 4 == 2);
      check("cpu_video", vram_cpu_video, exp_vid);
      check("load_sr", load_sr, exp_load);
      check("ce_pixel", ce_pixel, exp_pix);
      check("ce_8m", ce_8m, exp_8m);
    end
  endtask

  task automatic go_to(input int p);
    while (phase != p) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_video"}, vram_cpu_video, 1);
    check({tag, "_load_sr"}, load_sr, 0);
    check({tag, "_ce_pixel"}, ce_pixel, 0);
    check({tag, "_ce_8m"}, ce_8m, 0);
    check({tag, "_we"}, vram_we, 0);
    check({tag, "_pending"}, wbuf_pending, 0);
    check({tag, "_snow"}, snow_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    reset = 1'b1;
    phase = 31;
    cnt31_i = 5'd31;
    ce_1m = 1'b0;
    pref_have_80_cols = 1'b0;
    pref_eoi_blanks = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    cpu_we = 1'b0;
    video_addr = 10'h2A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    reset = 1'b0;

    // 40-col free-running frame
    repeat (32) step(1'b0, '0, '0, 1'b0);

    // Posted write $41 -> $8123, retires in phase 1
    go_to(31);
    push(11'h123, 8'h41);
    step(1'b1, 16'h8123, 8'h41, 1'b0);
    check("pend_p0", wbuf_pending, 0);
    step(1'b0, '0, '0, 1'b0);
    check("we_p1", vram_we, 1);
    check("pend_p1", wbuf_pending, 1);
    step(1'b0, '0, '0, 1'b0);
    check("pend_p2", wbuf_pending, 0);

    // Two captures back-to-back inside the video slot: only the second is written
    go_to(2);
    push(11'h020, 8'hBB);
    step(1'b1, 16'h8010, 8'hAA, 1'b1);
    step(1'b1, 16'h8020, 8'hBB, 1'b1);
    check("pend_p4", wbuf_pending, 1);
    check("ovr_p4", overrun_o, 0);
    step(1'b0, '0, '0, 1'b0);
    check("ovr_p5", overrun_o, 1);
    check("pend_p5", wbuf_pending, 1);
    step(1'b0, '0, '0, 1'b0);
    check("ovr_p6", overrun_o, 0);
    check("we_p6", vram_we, 1);
    step(1'b0, '0, '0, 1'b0);
    check("pend_p7", wbuf_pending, 0);
    check("sb_after_ovr", sb.size(), 0);

    // 80-col: two video slots per cycle, top address bit from cnt31_i[4]
    go_to(31);
    nxt_80 = 1'b1;
    push(11'h7FF, 8'h5A);
    step(1'b1, 16'h87FF, 8'h5A, 1'b0);
    repeat (31) begin
      step(1'b0, '0, '0, 1'b0);
      if (phase == 4 || phase == 5)
        check("v80_addr_lo", vram_addr, {10'h2A5, 1'b0});
      if (phase == 20 || phase == 21)
        check("v80_addr_hi", vram_addr, {10'h2A5, 1'b1});
    end
    nxt_80 = 1'b0;
    step(1'b0, '0, '0, 1'b0);
    go_to(3);
    step(1'b0, '0, '0, 1'b0);
    check("v40_addr", vram_addr, {1'b0, 10'h2A5});

    // Pending entry still retires after switching to 2001 mode
    go_to(31);
    push(11'h055, 8'h77);
    step(1'b1, 16'h8055, 8'h77, 1'b0);
    nxt_eoi = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    check("we_modeswitch", vram_we, 1);
    step(1'b0, '0, '0, 1'b0);
    check("pend_modeswitch", wbuf_pending, 0);

    // 2001 mode: CPU read during video slot gives snow; write is immediate
    go_to(3);
    step(1'b0, 16'h8800, '0, 1'b0);
    check("eoi_addr_p4", vram_addr, 11'h000);
    check("snow_p4", snow_o, 0);
    step(1'b0, '0, '0, 1'b0);
    check("snow_p5", snow_o, 1);
    step(1'b0, '0, '0, 1'b0);
    check("snow_p6", snow_o, 0);
    go_to(31);
    push(11'h3FF, 8'hC3);
    step(1'b1, 16'h8FFF, 8'hC3, 1'b0);
    check("eoi_we_p0", vram_we, 1);
    step(1'b0, '0, '0, 1'b0);
    check("eoi_pend", wbuf_pending, 0);
    nxt_eoi = 1'b0;
    step(1'b0, '0, '0, 1'b0);

    // Reset one clock after a capture drops the entry
    go_to(31);
    step(1'b1, 16'h8123, 8'h99, 1'b0);
    nxt_rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    check("rst_we_masked", vram_we, 0);
    check("rst_pend_before", wbuf_pending, 1);
    nxt_rst = 1'b0;
    skip_sched = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    check_reset_vals("rst1");
    repeat (40) step(1'b0, '0, '0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
